// File: rtl/dominos_input_ctrl.sv
// rtl/dominos_input_ctrl.sv - Dominos player input conditioning: PS/2 keys, joystick merge, coin pulse queues

module dominos_coin_queue #(
    parameter int COIN_PULSE_CYCLES = 600000,
    parameter int COIN_GAP_CYCLES   = 600000,
    parameter int CNT_W             = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    output logic       coin_n,
    output logic [2:0] pend
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(COIN_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             req_q;
    logic             inc;
    logic             dec;

    // A credit arriving while the queue is full is dropped, even if one is popped this cycle.
    assign inc = req & ~req_q & (pend != 3'd7);
    assign dec = (state == IDLE) && (pend != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            pend   <= 3'd0;
            state  <= IDLE;
            timer  <= '0;
            coin_n <= 1'b1;
        end else begin
            req_q <= req;
            pend  <= pend + {2'b00, inc} - {2'b00, dec};
            case (state)
                IDLE: begin
                    if (dec) begin
                        timer  <= PULSE_LOAD;
                        state  <= PULSE;
                        coin_n <= 1'b0;
                    end
                end
                PULSE: begin
                    if (timer == '0) begin
                        timer  <= GAP_LOAD;
                        state  <= GAP;
                        coin_n <= 1'b1;
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    coin_n <= 1'b1;
                end
            endcase
        end
    end
endmodule

module dominos_input_ctrl #(
    parameter int COIN_PULSE_CYCLES = 600000,
    parameter int COIN_GAP_CYCLES   = 600000,
    parameter int CNT_W             = 20
) (
    input  logic        Clk_I,
    input  logic        Reset_I,
    input  logic [10:0] ps2_key_I,
    input  logic [15:0] joy0_I,
    input  logic [15:0] joy1_I,
    output logic        Coin1_O,
    output logic        Coin2_O,
    output logic        Start1_O,
    output logic        Start2_O,
    output logic        Up1_O,
    output logic        Down1_O,
    output logic        Left1_O,
    output logic        Right1_O,
    output logic        Up2_O,
    output logic        Down2_O,
    output logic        Left2_O,
    output logic        Right2_O,
    output logic [2:0]  Coin1_Pend_O,
    output logic [2:0]  Coin2_Pend_O
);
    // One latch per physical key so two keys sharing a function do not cancel each other.
    localparam int K_UP1 = 0,  K_DOWN1 = 1,  K_LEFT1 = 2,  K_RIGHT1 = 3;
    localparam int K_COIN1A = 4, K_COIN1B = 5, K_COIN2A = 6, K_COIN2B = 7;
    localparam int K_START1A = 8, K_START1B = 9, K_START2A = 10, K_START2B = 11;
    localparam int K_UP2 = 12, K_DOWN2 = 13, K_LEFT2 = 14, K_RIGHT2 = 15;

    logic        init_q;
    logic        old_tog;
    logic [15:0] keys;
    logic [15:0] key_sel;
    logic        ext;
    logic        up1, down1, left1, right1;
    logic        up2, down2, left2, right2;
    logic        start1, start2;
    logic        coinreq1, coinreq2;
    logic        unused_joy_bits;

    assign ext = ps2_key_I[8];
    assign unused_joy_bits = ^{joy0_I[15:8], joy1_I[15:8]};

    always_comb begin
        key_sel = '0;
        case (ps2_key_I[7:0])
            8'h75: key_sel[K_UP1]     = 1'b1;
            8'h72: key_sel[K_DOWN1]   = 1'b1;
            8'h6B: key_sel[K_LEFT1]   = 1'b1;
            8'h74: key_sel[K_RIGHT1]  = 1'b1;
            8'h29: key_sel[K_COIN1A]  = ~ext;
            8'h2E: key_sel[K_COIN1B]  = ~ext;
            8'h14: key_sel[K_COIN2A]  = ~ext;
            8'h36: key_sel[K_COIN2B]  = ~ext;
            8'h05: key_sel[K_START1A] = ~ext;
            8'h16: key_sel[K_START1B] = ~ext;
            8'h06: key_sel[K_START2A] = ~ext;
            8'h1E: key_sel[K_START2B] = ~ext;
            8'h2D: key_sel[K_UP2]     = ~ext;
            8'h2B: key_sel[K_DOWN2]   = ~ext;
            8'h23: key_sel[K_LEFT2]   = ~ext;
            8'h34: key_sel[K_RIGHT2]  = ~ext;
            default: ;
        endcase
    end

    assign up1    = keys[K_UP1]    | joy0_I[3];
    assign down1  = keys[K_DOWN1]  | joy0_I[2];
    assign left1  = keys[K_LEFT1]  | joy0_I[1];
    assign right1 = keys[K_RIGHT1] | joy0_I[0];
    assign up2    = keys[K_UP2]    | joy1_I[3];
    assign down2  = keys[K_DOWN2]  | joy1_I[2];
    assign left2  = keys[K_LEFT2]  | joy1_I[1];
    assign right2 = keys[K_RIGHT2] | joy1_I[0];

    assign start1   = keys[K_START1A] | keys[K_START1B] | joy0_I[5] | joy1_I[5];
    assign start2   = keys[K_START2A] | keys[K_START2B] | joy0_I[6] | joy1_I[6];
    assign coinreq1 = keys[K_COIN1A] | keys[K_COIN1B] | joy0_I[4] | joy0_I[7] | joy1_I[7];
    assign coinreq2 = keys[K_COIN2A] | keys[K_COIN2B] | joy1_I[4];

    always_ff @(posedge Clk_I or negedge Reset_I) begin
        if (!Reset_I) begin
            init_q   <= 1'b1;
            old_tog  <= 1'b0;
            keys     <= '0;
            Start1_O <= 1'b1;
            Start2_O <= 1'b1;
            Up1_O    <= 1'b1;
            Down1_O  <= 1'b1;
            Left1_O  <= 1'b1;
            Right1_O <= 1'b1;
            Up2_O    <= 1'b1;
            Down2_O  <= 1'b1;
            Left2_O  <= 1'b1;
            Right2_O <= 1'b1;
        end else begin
            // The first edge only resynchronises to the current toggle level.
            if (init_q) begin
                init_q  <= 1'b0;
                old_tog <= ps2_key_I[10];
            end else if (ps2_key_I[10] != old_tog) begin
                old_tog <= ps2_key_I[10];
                keys    <= (keys & ~key_sel) | (key_sel & {16{ps2_key_I[9]}});
            end
            Start1_O <= ~start1;
            Start2_O <= ~start2;
            Up1_O    <= ~(up1 & ~down1);
            Down1_O  <= ~(down1 & ~up1);
            Left1_O  <= ~(left1 & ~right1);
            Right1_O <= ~(right1 & ~left1);
            Up2_O    <= ~(up2 & ~down2);
            Down2_O  <= ~(down2 & ~up2);
            Left2_O  <= ~(left2 & ~right2);
            Right2_O <= ~(right2 & ~left2);
        end
    end

    dominos_coin_queue #(
        .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES),
        .COIN_GAP_CYCLES  (COIN_GAP_CYCLES),
        .CNT_W            (CNT_W)
    ) u_coin1 (
        .clk   (Clk_I),
        .rst_n (Reset_I),
        .req   (coinreq1),
        .coin_n(Coin1_O),
        .pend  (Coin1_Pend_O)
    );

    dominos_coin_queue #(
        .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES),
        .COIN_GAP_CYCLES  (COIN_GAP_CYCLES),
        .CNT_W            (CNT_W)
    ) u_coin2 (
        .clk   (Clk_I),
        .rst_n (Reset_I),
        .req   (coinreq2),
        .coin_n(Coin2_O),
        .pend  (Coin2_Pend_O)
    );
endmodule

// File: doc/dominos_input_ctrl.md
Name: dominos_input_ctrl

Overview:
- Conditions every player control input before it reaches the Dominos core inputs (coin, start, directions).
- Decodes PS/2 key events and merges them with the two MiSTer joystick words.
- Applies a direction-conflict rule to each player's stick.
- Queues coin requests and replays each one to the core as a fixed-width, active-low coin pulse.
- Runs on clk_sys (12 MHz).

Parameters:
- COIN_PULSE_CYCLES, 600000: coin output low time per credit (50 ms at 12 MHz).
- COIN_GAP_CYCLES, 600000: minimum high time between consecutive coin pulses.
- CNT_W, 20: width of the pulse/gap timer; must hold max(COIN_PULSE_CYCLES, COIN_GAP_CYCLES).

Ports:
- Clk_I  in  1  system clock (clk_sys)
- Reset_I  in  1  asynchronous reset, active-low
- ps2_key_I  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
- joy0_I  in  16  player 1 joystick; [0]R [1]L [2]D [3]U [4]coin [5]start1 [6]start2 [7]coin
- joy1_I  in  16  player 2 joystick, same layout
- Coin1_O, Coin2_O  out  1  coin pulses to core, active-low
- Start1_O, Start2_O  out  1  start buttons, active-low
- Up1_O, Down1_O, Left1_O, Right1_O  out  1  player 1 directions, active-low
- Up2_O, Down2_O, Left2_O, Right2_O  out  1  player 2 directions, active-low
- Coin1_Pend_O, Coin2_Pend_O  out  3  credits queued and not yet pulsed

Behaviour:
Reset:
- Clk_I is the only clock. Reset_I is asynchronous and active-low.
- While Reset_I=0: all _O control outputs are 1 (inactive), pending counts are 0, both coin FSMs are IDLE, all key latches are 0, and the init flag is set.
- Reset mid-pulse: coin outputs go high immediately; the queue is discarded.

PS/2 decode:
- old_tog register. On the first edge after reset, old_tog <= ps2_key_I[10] with no event (init flag clears).
- After that, an event occurs at any edge where ps2_key_I[10] != old_tog. At that edge the matching key latch <= ps2_key_I[9] and old_tog updates.
- Key map, bit 8 ignored:
  - 0x75 up1, 0x72 down1, 0x6B left1, 0x74 right1.
- Key map, bit 8 must be 0:
  - 0x29 and 0x2E: coin1.
  - 0x14 and 0x36: coin2.
  - 0x05 and 0x16: start1.
  - 0x06 and 0x1E: start2.
  - 0x2D up2, 0x2B down2, 0x23 left2, 0x34 right2.
- Each physical key has its own latch. A function is asserted when any of its latches is set (OR), so releasing one key does not cancel another key held for the same function.
- Unmapped codes are ignored.

Merge:
- dirs: player 1 key | joy0 bit; player 2 key | joy1 bit.
- start1 = keys | joy0[5] | joy1[5].
- start2 = keys | joy0[6] | joy1[6].
- coinreq1 = keys | joy0[4] | joy0[7] | joy1[7].
- coinreq2 = keys | joy1[4].

Conflict rule:
- If up and down are both asserted for a player, both outputs are inactive.
- Same for left and right.

Latency:
- Direction/start outputs are registered and inverted.
- A joystick change appears on the output 1 cycle later.
- A key event appears on the output 1 cycle after its latch edge.

Coin queue (per coin, independent):
- A rising edge of coinreq (registered previous value) increments pend, saturating at 7; an edge arriving at 7 is dropped.
- FSM states:
  - IDLE: if pend > 0, then pend--, timer <= COIN_PULSE_CYCLES-1, go to PULSE.
  - PULSE: Coin_O=0. Count down; at 0, timer <= COIN_GAP_CYCLES-1, go to GAP.
  - GAP: Coin_O=1. Count down; at 0, go to IDLE.
- Coin_O is registered: it goes low the cycle after the IDLE→PULSE transition and stays low for exactly COIN_PULSE_CYCLES cycles.
- An increment and a decrement in the same cycle leave pend unchanged.
- Edges arriving during PULSE or GAP are queued.
- Back-to-back credits: low COIN_PULSE_CYCLES, then high COIN_GAP_CYCLES+1 (gap plus the IDLE cycle).

Test Plan:
Bench parameters: COIN_PULSE_CYCLES=4, COIN_GAP_CYCLES=3.
1. Release reset with ps2_key_I[10]=1 held → no latch changes; all outputs 1; both pend=0.
2. Toggle event code 0x175 pressed=1, then toggle event 0x075 pressed=0 → Up1_O goes 0 one cycle after the first latch edge, returns to 1 one cycle after the second.
3. Press key 0x16 and joy0[5]=1, release 0x16 → Start1_O stays 0 until joy0[5]=0, then 1 next cycle.
4. joy1[0]=1 and joy1[1]=1 → Left2_O=Right2_O=1; drop joy1[1] → Right2_O=0 next cycle.
5. Three joy0[4] rising edges within 2 cycles → Coin1_Pend_O peaks at 2–3; Coin1_O shows three 4-cycle lows separated by 4-cycle highs; pend ends at 0.
6. Nine coin1 edges while PULSE is active → pend saturates at 7, total pulses = 8 (1 in flight + 7); assert Reset_I=0 mid-pulse → Coin1_O=1 and pend=0 asynchronously.
